// File: rtl/bit_masked_mem_p.sv
// bit_masked_mem_p: parametrised single-port bit-masked RMW memory with zero-init sweep, registered read and ready flag
module bit_masked_mem_p #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = 256,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enb,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] masked,
  input  logic              clr,
  output logic              ready,
  output logic              init_done,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid
);
  typedef enum logic {INIT, RUN} state_t;
  localparam state_t            RST_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wa;
  logic              init_done_q, init_done_d, r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q, r_data_d, rd_word, wr_word;
  logic              in_range, accept, last, we;
  // Address decode and command acceptance; clr in RUN wins over a same-cycle command
  always_comb begin
    in_range = {1'b0, addr} < DEPTH_L;
    rd_word  = in_range ? mem[addr] : '0;
    accept   = (state_q == RUN) && enb && !clr;
    last     = (state_q == INIT) && (cnt_q == LAST);
  end
  // Next state: INIT sweeps every word once, RUN re-enters INIT on clr
  always_comb begin
    state_d     = last ? RUN : ((state_q == RUN) && clr) ? INIT : state_q;
    cnt_d       = (state_q == INIT && !last) ? cnt_q + 1'b1 : '0;
    init_done_d = last;
    r_valid_d   = accept && !wr;
    r_data_d    = r_valid_d ? rd_word : r_data_q;
  end
  // Single write port shared by the init sweep (zeros) and masked read-modify-write commands
  always_comb begin
    we      = rst_n && ((state_q == INIT) || (accept && wr && in_range));
    wa      = (state_q == INIT) ? cnt_q : addr;
    wr_word = (state_q == INIT) ? '0 : (rd_word & ~masked) | (data & masked);
  end
  // Control and read-output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
    end
  end
  // Storage array, never reset directly
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wr_word;
  end
  assign ready     = (state_q == RUN);
  assign init_done = init_done_q;
  assign r_valid   = r_valid_q;
  assign r_data    = r_data_q;
endmodule

// File: tb/tb_bit_masked_mem_p.sv
// tb_bit_masked_mem_p: scoreboard bench driving a 256-word and a 200-word instance with identical commands
module tb_bit_masked_mem_p;
  logic        clk = 1'b0, rst_n = 1'b0, enb = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] data = '0, masked = '0;
  logic        ready_a, init_done_a, r_valid_a, ready_b, init_done_b, r_valid_b;
  logic [31:0] r_data_a, r_data_b;
  logic [31:0] ma [256];
  logic [31:0] mb [200];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] last_a = '0, last_b = '0;
  int          tests = 0, fails = 0;

  bit_masked_mem_p dut_a (
    .clk(clk), .rst_n(rst_n), .enb(enb), .wr(wr), .addr(addr), .data(data), .masked(masked),
    .clr(clr), .ready(ready_a), .init_done(init_done_a), .r_data(r_data_a), .r_valid(r_valid_a)
  );
  bit_masked_mem_p #(.DEPTH(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .enb(enb), .wr(wr), .addr(addr), .data(data), .masked(masked),
    .clr(clr), .ready(ready_b), .init_done(init_done_b), .r_data(r_data_b), .r_valid(r_valid_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops expected read data on every r_valid, otherwise r_data must hold
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      last_a = '0;
      last_b = '0;
    end else begin
      if (r_valid_a) begin
        if (qa.size() == 0) chk("a unexpected r_valid", r_valid_a, 0);
        else begin
          last_a = qa.pop_front();
          chk("a read data", r_data_a, last_a);
        end
      end else chk("a r_data hold", r_data_a, last_a);
      if (r_valid_b) begin
        if (qb.size() == 0) chk("b unexpected r_valid", r_valid_b, 0);
        else begin
          last_b = qb.pop_front();
          chk("b read data", r_data_b, last_b);
        end
      end else chk("b r_data hold", r_data_b, last_b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) ma[i] = '0;
    for (int i = 0; i < 200; i++) mb[i] = '0;
  endtask

  // called on the first negedge of a sweep; optionally throws commands and clr at the busy memories
  task automatic wait_init(input bit spam);
    int n, rb, da, db;
    n = 0; rb = -1; da = 0; db = 0;
    while (!ready_a && n < 600) begin
      if (ready_b && rb < 0) rb = n;
      da += int'(init_done_a);
      db += int'(init_done_b);
      if (spam && !ready_b) begin
        enb = 1'b1; wr = 1'($urandom); addr = 8'($urandom); data = '1; masked = '1; clr = 1'($urandom);
      end else begin
        enb = 1'b0; clr = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    enb = 1'b0; clr = 1'b0;
    if (ready_b && rb < 0) rb = n;
    db += int'(init_done_b);
    chk("a init busy cycles", n, 256);
    chk("a init_done with ready", init_done_a, 1);
    chk("a early init_done", da, 0);
    chk("b init busy cycles", rb, 200);
    chk("b init_done pulses", db, 1);
    @(negedge clk);
    chk("a init_done width", init_done_a, 0);
    chk("a ready holds", ready_a, 1);
    chk("b ready holds", ready_b, 1);
    clear_model();
  endtask

  task automatic idle(input int n);
    enb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_cmd(input logic [7:0] a, input logic [31:0] d, input logic [31:0] m);
    enb = 1'b1; wr = 1'b1; addr = a; data = d; masked = m;
    ma[a] = (ma[a] & ~m) | (d & m);
    if (a < 200) mb[a] = (mb[a] & ~m) | (d & m);
    @(negedge clk);
  endtask

  task automatic rd_cmd(input logic [7:0] a, input logic [31:0] ea, input logic [31:0] eb);
    enb = 1'b1; wr = 1'b0; addr = a; data = $urandom; masked = $urandom;
    qa.push_back(ea);
    qb.push_back(eb);
    @(negedge clk);
  endtask

  task automatic rd_model(input logic [7:0] a);
    rd_cmd(a, ma[a], (a < 200) ? mb[a] : 32'h0);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0]  a;
      logic [31:0] m;
      int          sel, ms;
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      ms  = $urandom_range(0, 3);
      m   = (ms == 0) ? 32'h0 : (ms == 1) ? 32'hFFFF_FFFF : $urandom;
      sel = $urandom_range(0, 4);
      if (sel == 0) idle(1);
      else if (sel <= 2) wr_cmd(a, $urandom, m);
      else rd_model(a);
    end
    idle(2);
  endtask

  task automatic readback_all();
    for (int i = 0; i < 256; i++) rd_model(8'(i));
    idle(2);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    chk("reset ready_a", ready_a, 0);
    chk("reset r_valid_a", r_valid_a, 0);
    chk("reset r_data_a", r_data_a, 0);
    chk("reset init_done_a", init_done_a, 0);
    rst_n = 1'b1;
    wait_init(1'b0);
    // 1: freshly swept word reads zero
    rd_cmd(8'h37, 32'h0, 32'h0);
    idle(2);
    // 2: masked write keeps unmasked bits
    wr_cmd(8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr_cmd(8'd5, 32'h0000_0000, 32'h0000_FF00);
    rd_cmd(8'd5, 32'hFFFF_00FF, 32'hFFFF_00FF);
    idle(2);
    // 3: read right after write, then neighbouring word
    wr_cmd(8'd9, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    rd_cmd(8'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    rd_cmd(8'd10, 32'h0, 32'h0);
    idle(2);
    rand_phase(300);
    // 4: clr with a same-cycle write, sweep re-zeroes
    wr_cmd(8'd1, 32'h1234_5678, 32'hFFFF_FFFF);
    enb = 1'b1; wr = 1'b1; addr = 8'd2; data = 32'hFFFF_FFFF; masked = 32'hFFFF_FFFF; clr = 1'b1;
    @(negedge clk);
    enb = 1'b0; clr = 1'b0;
    wait_init(1'b1);
    rd_cmd(8'd1, 32'h0, 32'h0);
    rd_cmd(8'd2, 32'h0, 32'h0);
    idle(2);
    // 6: out-of-range write/read on the 200-word instance
    wr_cmd(8'd250, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd_cmd(8'd250, 32'hDEAD_BEEF, 32'h0);
    idle(2);
    readback_all();
    rd_cmd(8'd250, 32'hDEAD_BEEF, 32'h0);
    idle(2);
    // 5: reset in the middle of a sweep
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset ready_a", ready_a, 0);
    chk("mid reset ready_b", ready_b, 0);
    chk("mid reset r_data_a", r_data_a, 0);
    chk("mid reset r_valid_a", r_valid_a, 0);
    chk("mid reset init_done_a", init_done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(1'b1);
    readback_all();
    rand_phase(300);
    readback_all();
    chk("a scoreboard drained", qa.size(), 0);
    chk("b scoreboard drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
